// File: rtl/datapath_multi.sv
// Multi-cycle MIPS-subset core: register file, small data memory and a
// five-state control FSM. Instruction words are presented on instr/instr_valid
// for the byte address on pc; the register file is observable through dbg_*.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | wait for instr_valid, latch instruction into ir
// S_DECODE | read rs/rt into a_reg/b_reg
// S_EXEC   | ALU op, latch alu_out/tr_zf; beq and unsupported ops retire
// S_MEM    | lw reads dmem into mdr; sw writes dmem and retires
// S_WB     | write alu_out or mdr back to the register file and retire
module datapath_multi #(
    parameter int DATA_W     = 32,
    parameter int NREG       = 32,
    parameter int DMEM_WORDS = 64,
    parameter int PC_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [PC_W-1:0]   pc,
    output logic              tr_zf,
    output logic              done,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int RIDX_W = $clog2(NREG);
    localparam int DM_W   = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t state, state_next;

    logic [31:0]       ir;
    logic [DATA_W-1:0] a_reg, b_reg, alu_out, mdr;
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] dmem [DMEM_WORDS];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, wr_idx;
    logic [DATA_W-1:0] imm_ext, alu_res, rs_val, rt_val, wr_data;
    logic [PC_W-1:0]   pc_plus4, br_off, pc_br, pc_next;
    logic [DM_W-1:0]   dm_idx;
    logic              legal, is_rtype, is_lw, is_sw, is_beq, wr_ok;
    logic              ld_ir, ld_ab, ld_alu, mem_rd, mem_wr, rf_wr, pc_ld;
    logic              unused_shamt;

    // Index 0 and indices beyond the implemented file always read as zero.
    function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
        logic [DATA_W-1:0] val;
        if (idx == 5'd0 || {27'd0, idx} >= 32'(NREG)) begin
            val = '0;
        end else begin
            val = rf[idx[RIDX_W-1:0]];
        end
        return val;
    endfunction

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_ext  = DATA_W'($signed(ir[15:0]));
    assign br_off   = PC_W'($signed(ir[15:0]));
    assign pc_plus4 = pc + PC_W'(4);
    assign pc_br    = pc_plus4 + (br_off << 2);
    assign dm_idx   = alu_out[DM_W+1:2];
    assign rs_val   = rf_read(rs);
    assign rt_val   = rf_read(rt);
    assign dbg_data = rf_read(dbg_addr);
    assign wr_idx   = is_rtype ? rd : rt;
    assign wr_data  = is_lw ? mdr : alu_out;
    assign wr_ok    = (wr_idx != 5'd0) && ({27'd0, wr_idx} >= 32'(NREG)) == 1'b0;
    assign unused_shamt = &{1'b0, ir[10:6]};

    // Opcode/funct decode and the ALU, both driven from the latched ir.
    always_comb begin
        alu_res  = '0;
        legal    = 1'b0;
        is_rtype = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        case (op)
            6'b000000: begin
                is_rtype = 1'b1;
                legal    = 1'b1;
                case (funct)
                    6'b100000: alu_res = a_reg + b_reg;
                    6'b100010: alu_res = a_reg - b_reg;
                    6'b100100: alu_res = a_reg & b_reg;
                    6'b100101: alu_res = a_reg | b_reg;
                    6'b101010: alu_res = ($signed(a_reg) < $signed(b_reg)) ? DATA_W'(1) : '0;
                    default:   legal   = 1'b0;
                endcase
            end
            6'b001000: begin
                legal   = 1'b1;
                alu_res = a_reg + imm_ext;
            end
            6'b100011: begin
                legal   = 1'b1;
                is_lw   = 1'b1;
                alu_res = a_reg + imm_ext;
            end
            6'b101011: begin
                legal   = 1'b1;
                is_sw   = 1'b1;
                alu_res = a_reg + imm_ext;
            end
            6'b000100: begin
                legal   = 1'b1;
                is_beq  = 1'b1;
                alu_res = a_reg - b_reg;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and per-state control strobes.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        ld_ir       = 1'b0;
        ld_ab       = 1'b0;
        ld_alu      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        rf_wr       = 1'b0;
        pc_ld       = 1'b0;
        pc_next     = pc_plus4;
        case (state)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ld_ir      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ld_ab      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (!legal) begin
                    done       = 1'b1;
                    illegal    = 1'b1;
                    pc_ld      = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    ld_alu = 1'b1;
                    if (is_beq) begin
                        done       = 1'b1;
                        pc_ld      = 1'b1;
                        state_next = S_FETCH;
                        if (alu_res == '0) begin
                            pc_next = pc_br;
                        end
                    end else if (is_lw || is_sw) begin
                        state_next = S_MEM;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    mem_rd     = 1'b1;
                    state_next = S_WB;
                end else begin
                    mem_wr     = 1'b1;
                    done       = 1'b1;
                    pc_ld      = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_WB: begin
                rf_wr      = 1'b1;
                done       = 1'b1;
                pc_ld      = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Datapath pipeline registers, zero flag and program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            tr_zf   <= 1'b0;
            pc      <= '0;
        end else begin
            if (ld_ir) begin
                ir <= instr;
            end
            if (ld_ab) begin
                a_reg <= rs_val;
                b_reg <= rt_val;
            end
            if (ld_alu) begin
                alu_out <= alu_res;
                tr_zf   <= (alu_res == '0);
            end
            if (mem_rd) begin
                mdr <= dmem[dm_idx];
            end
            if (pc_ld) begin
                pc <= pc_next;
            end
        end
    end

    // Register file: cleared by reset, written only in write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_wr && wr_ok) begin
            rf[wr_idx[RIDX_W-1:0]] <= wr_data;
        end
    end

    // Data memory keeps its contents across reset; the FSM gates writes.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            dmem[dm_idx] <= b_reg;
        end
    end

endmodule

// File: tb/tb_datapath_multi.sv
// Self-checking bench for datapath_multi: each retire is compared against an
// expectation queued when the instruction is issued.
module tb_datapath_multi;

    localparam int DATA_W     = 32;
    localparam int NREG       = 32;
    localparam int DMEM_WORDS = 64;
    localparam int PC_W       = 32;
    localparam int ALIAS_OFF  = 8 + 4 * DMEM_WORDS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       instr = '0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [PC_W-1:0]   pc;
    logic              tr_zf;
    logic              done;
    logic              illegal;
    logic [4:0]        dbg_addr = '0;
    logic [DATA_W-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          cyc;
        logic        ill;
        logic [31:0] pc;
        logic [4:0]  ridx;
        logic [31:0] rval;
        logic        zf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];

    datapath_multi #(
        .DATA_W(DATA_W), .NREG(NREG), .DMEM_WORDS(DMEM_WORDS), .PC_W(PC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .tr_zf(tr_zf), .done(done),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic add_step(input logic [31:0] ins, input string tag, input int cyc,
                            input logic ill, input logic [31:0] p, input logic [4:0] ri,
                            input logic [31:0] rv, input logic zf);
        exp_t e;
        e.tag = tag; e.cyc = cyc; e.ill = ill; e.pc = p;
        e.ridx = ri; e.rval = rv; e.zf = zf;
        prog.push_back(ins);
        sb.push_back(e);
    endtask

    // Present one instruction from a negedge in FETCH; returns cycles to done
    // (0 on timeout), illegal at retire, and pc once back in FETCH.
    task automatic exec_instr(input logic [31:0] ins, output int cyc,
                              output logic ill, output logic [31:0] pc_o);
        cyc = 0;
        ill = 1'b0;
        instr = ins;
        instr_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (done === 1'b1) begin
                cyc = k;
                ill = illegal;
                break;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        instr = '0;
        @(negedge clk);
        pc_o = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
        total++; if (done !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", done, illegal); end
        rst_n = 1'b1;
        @(negedge clk);
        dbg_addr = 5'd1;
        #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        total++; if (tr_zf !== 1'b0) begin bad++; $display("FAIL reset_zf got=%b exp=0", tr_zf); end
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL reset_r1 got=%h exp=0", dbg_data); end
    endtask

    task automatic test_addi();
        logic [31:0] ins, pc_o;
        int cyc;
        logic ill;
        exp_t e;
        add_step(32'h20010005, "addi_r1", 4, 1'b0, 32'h04, 5'd1, 32'd5, 1'b0);
        while (prog.size() > 0) begin
            ins = prog.pop_front();
            exec_instr(ins, cyc, ill, pc_o);
            e = sb.pop_front();
            dbg_addr = e.ridx;
            #1;
            total++; if (cyc !== e.cyc) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", e.tag, cyc, e.cyc); end
            total++; if (ill !== e.ill) begin bad++; $display("FAIL %s illegal got=%b exp=%b", e.tag, ill, e.ill); end
            total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", e.tag, pc_o, e.pc); end
            total++; if (dbg_data !== e.rval) begin bad++; $display("FAIL %s r%0d got=%h exp=%h", e.tag, e.ridx, dbg_data, e.rval); end
            total++; if (tr_zf !== e.zf) begin bad++; $display("FAIL %s zf got=%b exp=%b", e.tag, tr_zf, e.zf); end
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins, pc_o;
        int cyc;
        logic ill;
        exp_t e;
        add_step(32'h20020005, "addi_r2",   4, 1'b0, 32'h08, 5'd2,  32'd5, 1'b0);
        add_step(32'h00221822, "sub_zero",  4, 1'b0, 32'h0C, 5'd3,  32'd0, 1'b1);
        add_step(32'h0061202A, "slt_0_5",   4, 1'b0, 32'h10, 5'd4,  32'd1, 1'b0);
        add_step(32'h00243024, "and",       4, 1'b0, 32'h14, 5'd6,  32'd1, 1'b0);
        add_step(32'h00243825, "or",        4, 1'b0, 32'h18, 5'd7,  32'd5, 1'b0);
        add_step(32'h00224020, "add",       4, 1'b0, 32'h1C, 5'd8,  32'd10, 1'b0);
        add_step(32'h00614822, "sub_neg",   4, 1'b0, 32'h20, 5'd9,  32'hFFFF_FFFB, 1'b0);
        add_step(32'h0121502A, "slt_m5_5",  4, 1'b0, 32'h24, 5'd10, 32'd1, 1'b0);
        while (prog.size() > 0) begin
            ins = prog.pop_front();
            exec_instr(ins, cyc, ill, pc_o);
            e = sb.pop_front();
            dbg_addr = e.ridx;
            #1;
            total++; if (cyc !== e.cyc) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", e.tag, cyc, e.cyc); end
            total++; if (ill !== e.ill) begin bad++; $display("FAIL %s illegal got=%b exp=%b", e.tag, ill, e.ill); end
            total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", e.tag, pc_o, e.pc); end
            total++; if (dbg_data !== e.rval) begin bad++; $display("FAIL %s r%0d got=%h exp=%h", e.tag, e.ridx, dbg_data, e.rval); end
            total++; if (tr_zf !== e.zf) begin bad++; $display("FAIL %s zf got=%b exp=%b", e.tag, tr_zf, e.zf); end
        end
    endtask

    task automatic test_mem();
        logic [31:0] ins, pc_o;
        logic [15:0] off16;
        int cyc;
        logic ill;
        exp_t e;
        off16 = 16'(ALIAS_OFF);
        add_step(32'hAC010008,            "sw_r1_8",    4, 1'b0, 32'h28, 5'd1,  32'd5,  1'b0);
        add_step(32'h8C050008,            "lw_r5_8",    5, 1'b0, 32'h2C, 5'd5,  32'd5,  1'b0);
        add_step({16'hAC08, off16},       "sw_alias",   4, 1'b0, 32'h30, 5'd8,  32'd10, 1'b0);
        add_step(32'h8C0B0008,            "lw_alias",   5, 1'b0, 32'h34, 5'd11, 32'd10, 1'b0);
        add_step(32'h8C0C000B,            "lw_byteoff", 5, 1'b0, 32'h38, 5'd12, 32'd10, 1'b0);
        while (prog.size() > 0) begin
            ins = prog.pop_front();
            exec_instr(ins, cyc, ill, pc_o);
            e = sb.pop_front();
            dbg_addr = e.ridx;
            #1;
            total++; if (cyc !== e.cyc) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", e.tag, cyc, e.cyc); end
            total++; if (ill !== e.ill) begin bad++; $display("FAIL %s illegal got=%b exp=%b", e.tag, ill, e.ill); end
            total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", e.tag, pc_o, e.pc); end
            total++; if (dbg_data !== e.rval) begin bad++; $display("FAIL %s r%0d got=%h exp=%h", e.tag, e.ridx, dbg_data, e.rval); end
            total++; if (tr_zf !== e.zf) begin bad++; $display("FAIL %s zf got=%b exp=%b", e.tag, tr_zf, e.zf); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins, pc_o;
        int cyc;
        logic ill;
        exp_t e;
        add_step(32'h00216822, "sub_self",   4, 1'b0, 32'h3C, 5'd13, 32'd0, 1'b1);
        add_step(32'hFC21FFFF, "bad_opcode", 3, 1'b1, 32'h40, 5'd1,  32'd5, 1'b1);
        add_step(32'h00220807, "bad_funct",  3, 1'b1, 32'h44, 5'd1,  32'd5, 1'b1);
        add_step(32'h20000007, "addi_r0",    4, 1'b0, 32'h48, 5'd0,  32'd0, 1'b0);
        while (prog.size() > 0) begin
            ins = prog.pop_front();
            exec_instr(ins, cyc, ill, pc_o);
            e = sb.pop_front();
            dbg_addr = e.ridx;
            #1;
            total++; if (cyc !== e.cyc) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", e.tag, cyc, e.cyc); end
            total++; if (ill !== e.ill) begin bad++; $display("FAIL %s illegal got=%b exp=%b", e.tag, ill, e.ill); end
            total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", e.tag, pc_o, e.pc); end
            total++; if (dbg_data !== e.rval) begin bad++; $display("FAIL %s r%0d got=%h exp=%h", e.tag, e.ridx, dbg_data, e.rval); end
            total++; if (tr_zf !== e.zf) begin bad++; $display("FAIL %s zf got=%b exp=%b", e.tag, tr_zf, e.zf); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins, pc_o;
        int cyc;
        logic ill;
        exp_t e;
        add_step(32'h10220003, "beq_taken",  3, 1'b0, 32'h58, 5'd1, 32'd5, 1'b1);
        add_step(32'h10230003, "beq_not",    3, 1'b0, 32'h5C, 5'd1, 32'd5, 1'b0);
        add_step(32'h1000FFF7, "beq_back",   3, 1'b0, 32'h3C, 5'd1, 32'd5, 1'b1);
        while (prog.size() > 0) begin
            ins = prog.pop_front();
            exec_instr(ins, cyc, ill, pc_o);
            e = sb.pop_front();
            dbg_addr = e.ridx;
            #1;
            total++; if (cyc !== e.cyc) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", e.tag, cyc, e.cyc); end
            total++; if (ill !== e.ill) begin bad++; $display("FAIL %s illegal got=%b exp=%b", e.tag, ill, e.ill); end
            total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", e.tag, pc_o, e.pc); end
            total++; if (dbg_data !== e.rval) begin bad++; $display("FAIL %s r%0d got=%h exp=%h", e.tag, e.ridx, dbg_data, e.rval); end
            total++; if (tr_zf !== e.zf) begin bad++; $display("FAIL %s zf got=%b exp=%b", e.tag, tr_zf, e.zf); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ins, pc_o;
        int cyc;
        logic ill;
        exp_t e;
        instr = 32'h200EFFFF;
        instr_valid = 1'b0;
        dbg_addr = 5'd14;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (pc !== 32'h3C || instr_ready !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL stall_%0d got pc=%h ready=%b done=%b exp pc=3c ready=1 done=0", i, pc, instr_ready, done);
            end
        end
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL stall_r14 got=%h exp=0", dbg_data); end
        add_step(32'h200EFFFF, "addi_after_stall", 4, 1'b0, 32'h40, 5'd14, 32'hFFFF_FFFF, 1'b0);
        while (prog.size() > 0) begin
            ins = prog.pop_front();
            exec_instr(ins, cyc, ill, pc_o);
            e = sb.pop_front();
            dbg_addr = e.ridx;
            #1;
            total++; if (cyc !== e.cyc) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", e.tag, cyc, e.cyc); end
            total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", e.tag, pc_o, e.pc); end
            total++; if (dbg_data !== e.rval) begin bad++; $display("FAIL %s r%0d got=%h exp=%h", e.tag, e.ridx, dbg_data, e.rval); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ins, pc_o;
        int cyc;
        logic ill;
        exp_t e;
        instr = 32'h8C0F0008;
        instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        total++; if (pc !== 32'd0 || instr_ready !== 1'b1) begin bad++; $display("FAIL midrst_async got pc=%h ready=%b exp pc=0 ready=1", pc, instr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dbg_addr = 5'd15;
        #1;
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL midrst_r15 got=%h exp=0", dbg_data); end
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL midrst_pc got=%h exp=0", pc); end
        dbg_addr = 5'd1;
        #1;
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL midrst_r1 got=%h exp=0", dbg_data); end
        add_step(32'h8C0F0008, "lw_dmem_kept", 5, 1'b0, 32'h04, 5'd15, 32'd10, 1'b0);
        while (prog.size() > 0) begin
            ins = prog.pop_front();
            exec_instr(ins, cyc, ill, pc_o);
            e = sb.pop_front();
            dbg_addr = e.ridx;
            #1;
            total++; if (cyc !== e.cyc) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", e.tag, cyc, e.cyc); end
            total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc got=%h exp=%h", e.tag, pc_o, e.pc); end
            total++; if (dbg_data !== e.rval) begin bad++; $display("FAIL %s r%0d got=%h exp=%h", e.tag, e.ridx, dbg_data, e.rval); end
            total++; if (tr_zf !== e.zf) begin bad++; $display("FAIL %s zf got=%b exp=%b", e.tag, tr_zf, e.zf); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_addi();
        test_alu();
        test_mem();
        test_illegal();
        test_branch();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
